// File: rtl/ysyx_22050243_ctrl_pkg.sv
// Shared definitions for the multi-cycle control FSM:
// opcodes, state encoding, halt causes and control bundle.
package ysyx_22050243_ctrl_pkg;

  localparam int CTRL_W = 14;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    HC_NONE    = 2'b00,
    HC_EBREAK  = 2'b01,
    HC_ILLEGAL = 2'b10,
    HC_TIMEOUT = 2'b11
  } hcause_t;

  typedef struct packed {
    logic       csr_r;
    logic       alu_src;
    logic [2:0] mem2reg;
    logic       reg_w;
    logic       mem_r;
    logic       mem_w;
    logic       branch;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/ysyx_22050243_ctrl_dec.sv
// Combinational opcode decoder producing the control bundle
// plus ebreak / illegal flags.
module ysyx_22050243_ctrl_dec
  import ysyx_22050243_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output ctrl_t      ctrl,
  output logic       ebreak,
  output logic       illegal
);

  localparam bit RV64 = (XLEN == 64);

  always_comb begin
    ctrl    = '0;
    ebreak  = 1'b0;
    illegal = 1'b0;
    unique case (1'b1)
      opcode == OP_LUI:
        ctrl = ctrl_t'(14'b0_0_010_1_0_0_0_00_000);
      opcode == OP_AUIPC:
        ctrl = ctrl_t'(14'b0_0_100_1_0_0_0_00_000);
      opcode == OP_JAL:
        ctrl = ctrl_t'(14'b0_0_011_1_0_0_0_01_000);
      opcode == OP_JALR:
        ctrl = ctrl_t'(14'b0_0_011_1_0_0_0_10_000);
      opcode == OP_BRANCH:
        ctrl = ctrl_t'(14'b0_0_000_0_0_0_1_00_001);
      opcode == OP_LOAD:
        ctrl = ctrl_t'(14'b0_1_001_1_1_0_0_00_000);
      opcode == OP_STORE:
        ctrl = ctrl_t'(14'b0_1_000_0_0_1_0_00_000);
      opcode == OP_IMM:
        ctrl = ctrl_t'(14'b0_1_000_1_0_0_0_00_011);
      opcode == OP_OP:
        ctrl = ctrl_t'(14'b0_0_000_1_0_0_0_00_010);
      opcode == OP_IMM32 && RV64:
        ctrl = ctrl_t'(14'b0_1_000_1_0_0_0_00_111);
      opcode == OP_32 && RV64:
        ctrl = ctrl_t'(14'b0_0_000_1_0_0_0_00_110);
      opcode == OP_FENCE:
        ctrl = '0;
      opcode == OP_SYSTEM && funct3 != 3'b000:
        ctrl = ctrl_t'(14'b1_0_101_1_0_0_0_00_000);
      opcode == OP_SYSTEM && funct3 == 3'b000:
        ebreak = 1'b1;
      default:
        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ysyx_22050243_ctrl_fsm.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/wb sequencing
// with bounded IFU/LSU waits and sticky halt.
module ysyx_22050243_ctrl_fsm
  import ysyx_22050243_ctrl_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] inst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_rsp_valid,
  output logic        lsu_req_valid,
  input  logic        lsu_req_ready,
  input  logic        lsu_rsp_valid,
  output logic        alu_src,
  output logic [2:0]  mem2reg,
  output logic        mem_r,
  output logic        mem_w,
  output logic        branch,
  output logic [1:0]  pc_src_ctrl,
  output logic [2:0]  alu_op,
  output logic        csr_r,
  output logic        ir_we,
  output logic        reg_we,
  output logic        pc_we,
  output logic        halt,
  output logic [1:0]  halt_cause,
  output logic [2:0]  state
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t         st_q, st_d;
  hcause_t        hc_q, hc_d;
  ctrl_t          ctrl_q, dec_ctrl;
  logic           acc_q;
  logic [CW-1:0]  cnt_q;
  logic [6:0]     op_q;
  logic [2:0]     f3_q;
  logic           dec_ebreak, dec_illegal;
  logic           wait_st, req_fire, rsp_hit, expire;
  logic           inst_unused;

  assign inst_unused = ^{inst[31:15], inst[11:7]};

  ysyx_22050243_ctrl_dec #(
    .XLEN(XLEN)
  ) u_dec (
    .opcode (op_q),
    .funct3 (f3_q),
    .ctrl   (dec_ctrl),
    .ebreak (dec_ebreak),
    .illegal(dec_illegal)
  );

  assign ifu_req_valid = (st_q == S_FETCH) && !acc_q;
  assign lsu_req_valid = (st_q == S_MEM) && !acc_q;
  assign wait_st  = (st_q == S_FETCH) || (st_q == S_MEM);
  assign req_fire = (ifu_req_valid && ifu_req_ready) ||
                    (lsu_req_valid && lsu_req_ready);
  // response counts from the accept cycle onward
  assign rsp_hit  = (acc_q || req_fire) &&
                    ((st_q == S_FETCH) ? ifu_rsp_valid : lsu_rsp_valid);
  assign expire   = wait_st && !rsp_hit && (cnt_q == CNT_LAST);

  assign ir_we       = (st_q == S_FETCH) && rsp_hit;
  assign pc_we       = (st_q == S_WB);
  assign reg_we      = pc_we && ctrl_q.reg_w;
  assign halt        = (st_q == S_HALT);
  assign halt_cause  = hc_q;
  assign state       = st_q;
  assign alu_src     = ctrl_q.alu_src;
  assign mem2reg     = ctrl_q.mem2reg;
  assign mem_r       = ctrl_q.mem_r;
  assign mem_w       = ctrl_q.mem_w;
  assign branch      = ctrl_q.branch;
  assign pc_src_ctrl = ctrl_q.pc_src;
  assign alu_op      = ctrl_q.alu_op;
  assign csr_r       = ctrl_q.csr_r;

  always_comb begin
    st_d = st_q;
    hc_d = hc_q;
    case (st_q)
      S_IDLE:
        if (start) st_d = S_FETCH;
      S_FETCH, S_MEM:
        if (rsp_hit) begin
          st_d = (st_q == S_FETCH) ? S_DECODE : S_WB;
        end else if (expire) begin
          st_d = S_HALT;
          hc_d = HC_TIMEOUT;
        end
      S_DECODE:
        if (dec_ebreak) begin
          st_d = S_HALT;
          hc_d = HC_EBREAK;
        end else if (dec_illegal) begin
          st_d = S_HALT;
          hc_d = HC_ILLEGAL;
        end else begin
          st_d = S_EXEC;
        end
      S_EXEC:
        st_d = (ctrl_q.mem_r || ctrl_q.mem_w) ? S_MEM : S_WB;
      S_WB:
        st_d = S_FETCH;
      S_HALT:
        st_d = S_HALT;
      default:
        st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= S_IDLE;
      hc_q   <= HC_NONE;
      acc_q  <= 1'b0;
      cnt_q  <= '0;
      op_q   <= '0;
      f3_q   <= '0;
      ctrl_q <= '0;
    end else begin
      st_q <= st_d;
      hc_q <= hc_d;
      if (wait_st && st_d == st_q) begin
        acc_q <= acc_q || req_fire;
        cnt_q <= cnt_q + 1'b1;
      end else begin
        acc_q <= 1'b0;
        cnt_q <= '0;
      end
      if (ir_we) begin
        op_q <= inst[6:0];
        f3_q <= inst[14:12];
      end
      if (st_q == S_DECODE && st_d == S_EXEC) ctrl_q <= dec_ctrl;
    end
  end

endmodule
